div_seq: RTL
============

Name: div_seq

Overview:
- Parametrised, multi-cycle, radix-2 restoring divider with a start/done handshake and signed or unsigned operation selected per operation.
- Generalised sequential successor to the team's single-cycle 32-bit combinational divider; keeps the same result packing and error conventions.
- Sits beside the ALU and feeds the HI/LO registers.
- Trades latency (WIDTH+2 cycles) for area and timing.

Parameters:
- WIDTH, 32, operand width in bits; legal values are even and ≥4.
- CW, clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only when busy=0
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned divide; sampled with start
- A  input  WIDTH  dividend; sampled with start
- B  input  WIDTH  divisor; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when Y and V are valid
- V  output  1  error flag (divide-by-zero or signed overflow); valid with done, held afterwards
- Y  output  2*WIDTH  {remainder, quotient}; Y[2W-1:W] = remainder, Y[W-1:0] = quotient

Behaviour:
- Clock/reset: one clock domain (clk). Reset is asynchronous, active-low (reset_n).
- Reset values: state = IDLE; busy = 0; done = 0; V = 0; Y = 0; all internal registers = 0.
- Reset asserted mid-operation aborts the operation immediately. No done is issued.
- State IDLE, start=1:
  - Latch signed_op, A, B.
  - If B==0: go to DONE. Y = all ones, V = 1.
  - Else: load the magnitudes |A| and |B| (if signed_op and the MSB is set, magnitude = ~x+1; otherwise x unchanged). Record the remainder sign = signed_op & A[W-1]. Record the quotient sign = signed_op & (A[W-1]^B[W-1]). Clear the partial remainder, load counter = WIDTH, go to CALC.
- State IDLE, start=0: stay in IDLE. Outputs hold their last values.
- State CALC: one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Trial subtract of |B|, computed at WIDTH+1 bits.
  - If the result is non-negative: keep the difference and set the quotient LSB to 1.
  - Decrement the counter. When the counter reaches 1, go to FIX on the next edge.
- State FIX:
  - Apply the signs: if the quotient sign is set, quotient = ~q+1. If the remainder sign is set, remainder = ~r+1.
  - Signed overflow: signed_op=1, A = 100…0, B = all ones. Result is Y = {0, 100…0}, V = 1.
  - Otherwise V = 0.
  - Register Y and go to DONE.
- State DONE: done = 1 for exactly one cycle, then go to IDLE.
- busy = 1 in CALC, FIX and DONE.
- Latency: done is high on the (WIDTH+2)th rising edge after the edge that sampled start. For divide-by-zero it is the 1st edge.
- Back-to-back: start may be reasserted in the cycle after done (state IDLE).
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the operation in progress.
- Y and V are stable from done until the next accepted start. They change only in FIX or DONE.
- Remainder sign follows the dividend. Quotient truncates toward zero. |remainder| < |divisor| always holds.
- Unsigned mode never sets V except on divide-by-zero.

Test Plan:
- Unsigned divide: WIDTH=32, signed_op=0, A=100, B=7, start for 1 cycle -> done exactly 34 cycles later. Y[31:0] = 14, Y[63:32] = 2, V = 0, busy high during cycles 1–34.
- Signed with negative dividend: signed_op=1, A=0xFFFFFFF9 (−7), B=2 -> Y = {0xFFFFFFFF, 0xFFFFFFFD}, V = 0. The same operands with signed_op=0 -> Y = {0x00000001, 0x7FFFFFFC}.
- Divide-by-zero: A=0x12345678, B=0 (either mode) -> done after 1 cycle. Y = 0xFFFFFFFFFFFFFFFF, V = 1. A following 100/7 clears V to 0.
- Signed overflow: signed_op=1, A=0x80000000, B=0xFFFFFFFF -> Y = {0x00000000, 0x80000000}, V = 1. Also A=−8, B=3 -> Q = 0xFFFFFFFE, R = 0xFFFFFFFE.
- Handshake and reset:
  - Pulse start again at cycle 10 of an operation with different operands -> it is ignored and the first result is unchanged.
  - Pulse start in the cycle after done -> accepted.
  - Drive reset_n low at cycle 15 -> busy, done, V and Y go to 0 immediately, and no done pulse follows.
- Randomised sweep: WIDTH=8, all 65,536 operand pairs in both modes -> checked against a reference model (truncating division, remainder takes the dividend's sign, error rules as above).

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider, signed or unsigned per operation.
// One quotient bit per cycle on operand magnitudes. The signs are applied in a final fix-up cycle.
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   start          one-cycle request, accepted only while busy=0
//   signed_op      1 = two's-complement divide, 0 = unsigned (sampled with start)
//   A, B           dividend / divisor (sampled with start)
//   busy           high from the accepted start through the done cycle
//   done           one-cycle pulse when Y and V are valid
//   V              divide-by-zero or signed-overflow flag, held until the next operation
//   Y              {remainder, quotient}
module div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 V,
  output logic [2*WIDTH-1:0]   Y
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic             sop_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             qsign;
  logic             rsign;
  logic [CW-1:0]    cnt;

  // Operand magnitudes at the moment start is accepted
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  assign a_mag_c = (signed_op && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag_c = (signed_op && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  // Shifted partial remainder and trial subtract, one extra bit for the borrow
  logic [WIDTH:0] shift_c;
  logic [WIDTH:0] diff_c;
  assign shift_c = {rem, quo[WIDTH-1]};
  assign diff_c  = shift_c - {1'b0, bmag};

  // Sign fix-up and the single signed overflow case (MIN / -1)
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;
  logic             ovf_c;
  assign q_fix_c = qsign ? (~quo + WIDTH'(1)) : quo;
  assign r_fix_c = rsign ? (~rem + WIDTH'(1)) : rem;
  assign ovf_c   = sop_r && (a_r == MIN_NEG) && (b_r == '1);

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      V     <= 1'b0;
      Y     <= '0;
      sop_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      bmag  <= '0;
      rem   <= '0;
      quo   <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sop_r <= signed_op;
            a_r   <= A;
            b_r   <= B;
            busy  <= 1'b1;
            if (B == '0) begin
              // Divide-by-zero answers immediately without iterating
              Y     <= '1;
              V     <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              quo   <= a_mag_c;
              bmag  <= b_mag_c;
              rem   <= '0;
              rsign <= signed_op & A[WIDTH-1];
              qsign <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          // Dividend bits shift out of quo as quotient bits shift in
          if (!diff_c[WIDTH]) begin
            rem <= diff_c[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shift_c[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          Y     <= {r_fix_c, q_fix_c};
          V     <= ovf_c;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
